cla_serial_sub: RTL
===================

Name: cla_serial_sub

Overview:
- Multi-cycle subtractor: DIFF = A - B - BIN, computed 2 bits per clock by a 2-bit carry-lookahead slice.
- It is the inverse-direction companion of the team's 2-bit CLA adder.
- Used where area matters more than latency (datapath ALU back-end, counters needing wide decrement).
- START/READY/DONE handshake; result is held until the next accepted START.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- START  input  1  request; accepted only when READY=1
- A  input  WIDTH  minuend, sampled on accepted START
- B  input  WIDTH  subtrahend, sampled on accepted START
- BIN  input  1  borrow-in, sampled on accepted START
- READY  output  1  high when idle and able to accept START
- DIFF  output  WIDTH  result
- BOUT  output  1  borrow-out (unsigned underflow)
- OVF  output  1  two's-complement signed overflow
- DONE  output  1  one-cycle pulse when DIFF/BOUT/OVF update

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE; READY=1; DIFF=0; BOUT=0; OVF=0; DONE=0; internal registers cleared. Reset overrides all other inputs and aborts any operation in progress; no DONE is produced for the aborted operation.
- Arithmetic: A + ~B + ~BIN. Internal carry c is initialised to ~BIN. BOUT = ~(final carry).
- OVF = (A[MSB] != B[MSB]) && (DIFF[MSB] != A[MSB]), using the latched operands.
- FSM states: IDLE, RUN, FIN.
  - IDLE: READY=1. START=1 latches A, ~B, c=~BIN, clears digit index k=0, then goes to RUN.
  - RUN: READY=0. Each cycle feeds operand bits [2k+1:2k] and c to the slice. The 2 result bits are written into a shadow register; c is updated from the slice COUT; k increments. After digit WIDTH/2-1, goes to FIN.
  - FIN: copies shadow to DIFF, BOUT and OVF on the same edge; DONE=1 for this one cycle; READY=0; returns to IDLE.
- Latency: START accepted at edge 0 → RUN for WIDTH/2 cycles → DONE high during cycle WIDTH/2+1. For WIDTH=8, DONE is high in the 6th cycle after acceptance. Next START is accepted one cycle after DONE.
- DIFF/BOUT/OVF are stable outside the FIN update edge; they never show partial results.
- START while READY=0 is ignored (no queuing). Operand changes after acceptance have no effect.
- Carry across digit boundaries is exact; k wraps to 0 only on a new acceptance.

Optional Feature:
- Macro CLA_SERIAL_SUB_ADD_MODE_EN.
- Defined:
  - Extra input port SUB (1 bit), sampled with the operands.
  - SUB=1 gives subtraction as above.
  - SUB=0 gives A + B + BIN: B is not inverted, c is initialised to BIN, BOUT = final carry (carry-out), and OVF = (A[MSB]==B[MSB]) && (DIFF[MSB]!=A[MSB]).
- Undefined: no SUB port; subtract only.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2
  - DIGIT_W=2
  - index-width helper clog2(WIDTH/2)
- Sub-module cla_slice_2b: combinational 2-bit generate/propagate slice.
  - Inputs X[1:0], Y[1:0], CI; outputs S[1:0], CO.
  - CO = G1 | P1&G0 | P1&P0&CI.
  - Instantiated once and reused every cycle.

Test Plan (WIDTH=8):
- A=0x50, B=0x20, BIN=0 → DIFF=0x30, BOUT=0, OVF=0. DONE pulses exactly 6 cycles after acceptance; READY returns to 1 the next cycle.
- A=0x00, B=0x01, BIN=0 → DIFF=0xFF, BOUT=1, OVF=0.
- A=0x80, B=0x01, BIN=0 → DIFF=0x7F, BOUT=0, OVF=1. Also A=0x10, B=0x0F, BIN=1 → DIFF=0x00, BOUT=0, OVF=0.
- Accept A=0x05, B=0x03; during RUN pulse START with A=0xFF, B=0x00 → second request ignored; DIFF=0x02; single DONE.
- Accept A=0x50, B=0x20, BIN=0; assert RST in RUN cycle 2 → next cycle READY=1, DIFF=0, BOUT=0, OVF=0, DONE=0, no DONE afterwards. New START A=0x09, B=0x04, BIN=0 → DIFF=0x05.
- With CLA_SERIAL_SUB_ADD_MODE_EN: SUB=0, A=0xFF, B=0x01, BIN=0 → DIFF=0x00, BOUT=1, OVF=0. SUB=0, A=0x7F, B=0x01, BIN=0 → DIFF=0x80, OVF=1.

Source files
------------

// File: rtl/cla_serial_sub_pkg.sv
// Shared types and constants for the serial 2-bit CLA subtractor.
// Optional build macro: CLA_SERIAL_SUB_ADD_MODE_EN.
package cla_serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  // Index width for n digits; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla_serial_sub_if.sv
// Request/result bundle for cla_serial_sub.
// Optional build macro: CLA_SERIAL_SUB_ADD_MODE_EN adds the SUB select.
interface cla_serial_sub_if #(parameter int WIDTH = 8);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
  logic             SUB;
`endif
  logic             READY;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
  logic             OVF;
  logic             DONE;

  modport master (
    output START, A, B, BIN,
`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
    output SUB,
`endif
    input  READY, DIFF, BOUT, OVF, DONE
  );

  modport slave (
    input  START, A, B, BIN,
`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
    input  SUB,
`endif
    output READY, DIFF, BOUT, OVF, DONE
  );
endinterface

// File: rtl/cla_serial_sub_slice.sv
// Combinational 2-bit generate/propagate carry-lookahead slice.
// Zero latency; no flow control.
module cla_slice_2b (
  input  logic [1:0] X,
  input  logic [1:0] Y,
  input  logic       CI,
  output logic [1:0] S,
  output logic       CO
);
  logic [1:0] w_g;
  logic [1:0] w_p;
  logic       w_c1;

  assign w_g  = X & Y;
  assign w_p  = X ^ Y;
  assign w_c1 = w_g[0] | (w_p[0] & CI);
  assign CO   = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & CI);
  assign S    = w_p ^ {w_c1, CI};
endmodule

// File: rtl/cla_serial_sub.sv
// Serial A - B - BIN, 2 bits per clock; DONE pulses WIDTH/2+1 cycles after START is accepted.
// START is ignored while READY=0; optional add mode via CLA_SERIAL_SUB_ADD_MODE_EN.
module cla_serial_sub
  import cla_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             CLK,
  input logic             RST,
  cla_serial_sub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int KW   = clog2(NDIG);
  localparam logic [KW-1:0] LAST_K = KW'(NDIG - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("cla_serial_sub: WIDTH must be even and >= 2");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_done;
  logic             r_ready;

  logic             w_sub_in;
  logic             w_sub_op;
  logic [1:0]       w_x;
  logic [1:0]       w_y;
  logic [1:0]       w_s;
  logic             w_co;

`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
  logic             r_sub;
  assign w_sub_in = bus.SUB;
  assign w_sub_op = r_sub;
`else
  assign w_sub_in = 1'b1;
  assign w_sub_op = 1'b1;
`endif

  assign w_x = r_a[{r_k, 1'b0} +: DIGIT_W];
  assign w_y = r_b[{r_k, 1'b0} +: DIGIT_W];

  cla_slice_2b u_slice (
    .X  (w_x),
    .Y  (w_y),
    .CI (r_c),
    .S  (w_s),
    .CO (w_co)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_k      <= '0;
      r_shadow <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
      r_sub    <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // READY is held low for the DONE cycle, so the next START lands one cycle later.
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          if (r_ready && bus.START) begin
            r_a     <= bus.A;
            r_b     <= w_sub_in ? ~bus.B : bus.B;
            r_c     <= w_sub_in ? ~bus.BIN : bus.BIN;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_state <= ST_RUN;
`ifdef CLA_SERIAL_SUB_ADD_MODE_EN
            r_sub   <= bus.SUB;
`endif
          end
        end
        ST_RUN: begin
          r_shadow[{r_k, 1'b0} +: DIGIT_W] <= w_s;
          r_c <= w_co;
          r_k <= r_k + 1'b1;
          if (r_k == LAST_K) r_state <= ST_FIN;
        end
        ST_FIN: begin
          // r_b holds the effective addend, so one overflow test covers both modes.
          r_diff  <= r_shadow;
          r_bout  <= w_sub_op ? ~r_c : r_c;
          r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_shadow[WIDTH-1] != r_a[WIDTH-1]);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.READY = r_ready;
  assign bus.DIFF  = r_diff;
  assign bus.BOUT  = r_bout;
  assign bus.OVF   = r_ovf;
  assign bus.DONE  = r_done;
endmodule
